// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer post-processing blocks:
// default vector geometry, index-width helper and the argmax FSM states.
package nn_pkg;

   localparam int NN_N = 16;   // default vector length (number of classes)
   localparam int NN_W = 16;   // default element width, signed

   // Index width for an N-entry vector; a single entry still needs one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/vec_argmax.sv
// Sequential argmax over a captured signed vector: one element compared per
// cycle, result held on a valid/ready output until the consumer takes it.
module vec_argmax
   import nn_pkg::*;
#(
   parameter  int N     = NN_N,
   parameter  int W     = NN_W,
   localparam int IDX_W = idx_w(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0][W-1:0]   in_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_W-1:0]      out_idx,
   output logic [W-1:0]          out_max
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   argmax_state_t    state_q, state_d;
   logic [W-1:0]     cap_q [N];
   logic [W-1:0]     cap_d [N];
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     best_val_q, best_val_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [W-1:0]     out_max_q, out_max_d;

   // Candidate for this scan step and the running best after including it.
   logic [W-1:0]     cand_val;
   logic             cand_wins;
   logic [W-1:0]     scan_val;
   logic [IDX_W-1:0] scan_idx;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_max   = out_max_q;

   // Strict signed compare so that ties keep the earliest (lowest) index.
   always_comb begin
      cand_val  = cap_q[cnt_q];
      cand_wins = ($signed(cand_val) > $signed(best_val_q));
      scan_val  = cand_wins ? cand_val : best_val_q;
      scan_idx  = cand_wins ? cnt_q    : best_idx_q;
   end

   // Next-state logic: capture in IDLE, walk the vector in SCAN, hold in DONE.
   always_comb begin
      state_d     = state_q;
      cap_d       = cap_q;
      cnt_d       = cnt_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_max_d   = out_max_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               for (int i = 0; i < N; i++) begin
                  cap_d[i] = in_vec[i];
               end
               best_val_d = in_vec[0];
               best_idx_d = '0;
               cnt_d      = IDX_W'(1);
               if (N == 1) begin
                  // Nothing left to compare: element 0 is the answer.
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_idx_d   = '0;
                  out_max_d   = in_vec[0];
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            best_val_d = scan_val;
            best_idx_d = scan_idx;
            if (cnt_q == LAST_IDX) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_idx_d   = scan_idx;
               out_max_d   = scan_val;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            // Result registers keep their value; only the valid flag drops.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; asynchronous reset discards any vector in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_max_q   <= '0;
         for (int i = 0; i < N; i++) begin
            cap_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_max_q   <= out_max_d;
         for (int i = 0; i < N; i++) begin
            cap_q[i] <= cap_d[i];
         end
      end
   end

endmodule

// File: tb/tb_vec_argmax.sv
// Directed bench for vec_argmax (N=16, W=16).
module tb_vec_argmax;

   localparam int N = 16;
   localparam int W = 16;
   localparam int IW = 4;

   typedef logic [N-1:0][W-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   vec_t          in_vec = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] out_idx;
   logic [W-1:0]  out_max;

   int checks = 0;
   int errors = 0;

   vec_argmax #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_max   (out_max)
   );

   always #5 clk = ~clk;

   // Present one vector, wait (bounded) for the result; optionally consume it.
   task automatic run_vec(input vec_t v, input bit consume, output int lat,
                          output logic [IW-1:0] idx, output logic [W-1:0] mx,
                          output bit got);
      @(negedge clk);
      in_vec   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got = out_valid;
      idx = out_idx;
      mx  = out_max;
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0 || out_max !== '0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b vld=%b idx=%0d max=%0d, need 1 0 0 0",
                  in_ready, out_valid, out_idx, out_max);
      end
      // Reach DONE with a non-zero result, then reset mid-cycle.
      v = '0;
      v[5] = 16'd7;
      run_vec(v, 1'b0, lat, idx, mx, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_pre_result: out_valid=%b need 1", out_valid);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_idx !== '0 || out_max !== '0) begin
         errors++;
         $display("FAIL reset_async: vld=%b idx=%0d max=%0d, need 0 0 0",
                  out_valid, out_idx, out_max);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: rdy=%b vld=%b, need 1 0", in_ready, out_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_peak();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      v = '0;
      v[5] = 16'd7;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd5 || mx !== 16'd7) begin
         errors++;
         $display("FAIL peak5: got=%b idx=%0d max=%0d, need 1 5 7", got, idx, mx);
      end
      checks++;
      if (lat != 15) begin
         errors++;
         $display("FAIL peak5_latency: %0d cycles, need 15", lat);
      end
      $display("peak5: idx=%0d max=%0d latency=%0d", idx, mx, lat);
   endtask

   task automatic test_ties();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      for (int i = 0; i < N; i++) v[i] = 16'd3;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd0 || mx !== 16'd3) begin
         errors++;
         $display("FAIL tie_all3: got=%b idx=%0d max=%0d, need 1 0 3", got, idx, mx);
      end
      $display("tie_all3: idx=%0d max=%0d", idx, mx);
      v = '0;
      v[2] = 16'd100;
      v[9] = 16'd100;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd2 || mx !== 16'd100) begin
         errors++;
         $display("FAIL tie_2_9: got=%b idx=%0d max=%0d, need 1 2 100", got, idx, mx);
      end
      $display("tie_2_9: idx=%0d max=%0d", idx, mx);
   endtask

   task automatic test_negatives();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      for (int i = 0; i < N; i++) v[i] = W'(-100 + i);
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd15 || mx !== 16'hFFAB) begin
         errors++;
         $display("FAIL neg_ramp: got=%b idx=%0d max=%0d, need 1 15 -85",
                  got, idx, $signed(mx));
      end
      $display("neg_ramp: idx=%0d max=%0d", idx, $signed(mx));
      for (int i = 0; i < N; i++) v[i] = 16'h8000;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd0 || mx !== 16'h8000) begin
         errors++;
         $display("FAIL neg_min: got=%b idx=%0d max=%0d, need 1 0 -32768",
                  got, idx, $signed(mx));
      end
      $display("neg_min: idx=%0d max=%0d", idx, $signed(mx));
      for (int i = 0; i < N; i++) v[i] = 16'hFFFF;
      v[15] = 16'h7FFF;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd15 || mx !== 16'h7FFF) begin
         errors++;
         $display("FAIL pos_max_last: got=%b idx=%0d max=%0d, need 1 15 32767",
                  got, idx, $signed(mx));
      end
      $display("pos_max_last: idx=%0d max=%0d", idx, $signed(mx));
   endtask

   task automatic test_backpressure();
      vec_t v;
      vec_t b;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      int bad;
      v = '0;
      v[5] = 16'd7;
      run_vec(v, 1'b0, lat, idx, mx, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_first: out_valid=%b need 1", out_valid);
      end
      // Hold the result while a competing vector is offered.
      b = '0;
      b[12] = 16'd300;
      bad = 0;
      @(negedge clk);
      in_vec   = b;
      in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 10) in_vec[0] = 16'd999;
         if (out_valid !== 1'b1 || out_idx !== 4'd5 || out_max !== 16'd7 || in_ready !== 1'b0)
            bad++;
      end
      in_vec[0] = 16'd0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold: %0d unstable cycles, need 0 (vld=%b idx=%0d max=%0d rdy=%b)",
                  bad, out_valid, out_idx, out_max, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
      end
      // in_valid is still high, so the next edge accepts vector b.
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'd12 || out_max !== 16'd300 || lat != 15) begin
         errors++;
         $display("FAIL bp_next: vld=%b idx=%0d max=%0d lat=%0d, need 1 12 300 15",
                  out_valid, out_idx, out_max, lat);
      end
      $display("bp_next: idx=%0d max=%0d latency=%0d", out_idx, out_max, lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      bit seen;
      v = '0;
      v[1] = 16'd77;
      @(negedge clk);
      in_vec   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_scan_reset: out_valid=1 seen, need never");
      end
      v = '0;
      v[3] = 16'd50;
      run_vec(v, 1'b1, lat, idx, mx, got);
      checks++;
      if (!got || idx !== 4'd3 || mx !== 16'd50) begin
         errors++;
         $display("FAIL after_scan_reset: got=%b idx=%0d max=%0d, need 1 3 50", got, idx, mx);
      end
      $display("after_scan_reset: idx=%0d max=%0d", idx, mx);
   endtask

   task automatic test_random();
      vec_t v;
      int lat;
      logic [IW-1:0] idx;
      logic [W-1:0] mx;
      bit got;
      logic [IW-1:0] e_idx;
      logic [W-1:0] e_max;
      int j;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) v[i] = W'($urandom);
         // Duplicate the largest-so-far at a later slot to exercise ties.
         e_idx = '0;
         e_max = v[0];
         for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(e_max)) begin
               e_max = v[i];
               e_idx = IW'(i);
            end
         end
         if (t % 2 == 0 && e_idx != 4'd15) begin
            j = int'(e_idx) + 1 + int'($urandom_range(0, 14 - int'(e_idx)));
            v[j] = e_max;
         end
         e_idx = '0;
         e_max = v[0];
         for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(e_max)) begin
               e_max = v[i];
               e_idx = IW'(i);
            end
         end
         run_vec(v, 1'b1, lat, idx, mx, got);
         checks++;
         if (!got || idx !== e_idx || mx !== e_max) begin
            errors++;
            $display("FAIL random%0d: got=%b idx=%0d max=%0d, need 1 %0d %0d",
                     t, got, idx, $signed(mx), e_idx, $signed(e_max));
         end
         $display("random%0d: idx=%0d max=%0d", t, idx, $signed(mx));
      end
   endtask

   initial begin
      test_reset();
      test_single_peak();
      test_ties();
      test_negatives();
      test_backpressure();
      test_reset_mid_scan();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
